// File: rtl/cpu_trace_checker.sv
// Trace checker beside the CPU: compares each PC step (and optional register
// value) against a loaded expected-trace table, then confirms the CPU halts.
//
// state   | meaning
// IDLE    | waiting for start, table writable
// RUN     | each PC change is checked against table[idx]
// HALTCHK | last entry seen, PC must stay put for TIMEOUT cycles
// DONE    | verdict valid and sticky, table writable
module cpu_trace_checker #(
  parameter int PC_W    = 9,
  parameter int DATA_W  = 16,
  parameter int NREG    = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64,
  parameter int CONT    = 0,
  localparam int RW = $clog2(NREG),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AW:0]       n_entries,
  input  logic              exp_we,
  input  logic [AW-1:0]     exp_addr,
  input  logic [PC_W-1:0]   exp_pc,
  input  logic              exp_ren,
  input  logic [RW-1:0]     exp_reg,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [PC_W-1:0]   pc,
  input  logic              wb_en,
  input  logic [RW-1:0]     wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2:0]        fail_code,
  output logic [AW-1:0]     fail_idx,
  output logic [AW:0]       err_count
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [2:0] FC_PC      = 3'd1;
  localparam logic [2:0] FC_DATA    = 3'd2;
  localparam logic [2:0] FC_TIMEOUT = 3'd3;
  localparam logic [2:0] FC_EXTRA   = 3'd4;

  typedef enum logic [1:0] {IDLE, RUN, HALTCHK, DONE} state_t;
  state_t state;

  logic [PC_W-1:0]   tbl_pc   [DEPTH];
  logic              tbl_ren  [DEPTH];
  logic [RW-1:0]     tbl_reg  [DEPTH];
  logic [DATA_W-1:0] tbl_data [DEPTH];
  logic [DATA_W-1:0] shadow   [NREG];

  logic [PC_W-1:0]   pc_q;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     last_idx;
  logic [TW-1:0]     tmr;
  logic [AW:0]       n_clamp;
  logic [AW:0]       err_inc;
  logic [DATA_W-1:0] reg_val;
  logic              armed, step, pc_bad, data_bad, tmr_zero, first;

  assign armed = (state == RUN) || (state == HALTCHK);

  // Table is frozen while a run is in progress.
  always_ff @(posedge clk) begin
    if (exp_we && !armed) begin
      tbl_pc[exp_addr]   <= exp_pc;
      tbl_ren[exp_addr]  <= exp_ren;
      tbl_reg[exp_addr]  <= exp_reg;
      tbl_data[exp_addr] <= exp_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) shadow[i] <= '0;
    end else if (wb_en) begin
      shadow[wb_reg] <= wb_data;
    end
  end

  always_comb begin
    step     = (pc != pc_q);
    // A write-back in the same cycle as the step is the value being checked.
    reg_val  = (wb_en && (wb_reg == tbl_reg[idx])) ? wb_data : shadow[tbl_reg[idx]];
    pc_bad   = (pc != tbl_pc[idx]);
    data_bad = tbl_ren[idx] && (reg_val != tbl_data[idx]);
    tmr_zero = (tmr == '0);
    first    = (fail_code == 3'd0);
    err_inc  = (&err_count) ? err_count : err_count + (AW+1)'(1);
    if (n_entries == '0)
      n_clamp = (AW+1)'(1);
    else if (n_entries > (AW+1)'(DEPTH))
      n_clamp = (AW+1)'(DEPTH);
    else
      n_clamp = n_entries;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc_q      <= '0;
      idx       <= '0;
      last_idx  <= '0;
      tmr       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= '0;
      fail_idx  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            pc_q      <= pc;
            idx       <= '0;
            tmr       <= TMAX;
            last_idx  <= AW'(n_clamp - (AW+1)'(1));
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= '0;
            fail_idx  <= '0;
            err_count <= '0;
          end
        end
        RUN: begin
          if (step) begin
            pc_q <= pc;
            tmr  <= TMAX;
            if (pc_bad || data_bad) begin
              err_count <= err_inc;
              if (first) begin
                fail_code <= pc_bad ? FC_PC : FC_DATA;
                fail_idx  <= idx;
              end
            end
            if ((pc_bad || data_bad) && (CONT == 0)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b0;
            end else if (idx == last_idx) begin
              state <= HALTCHK;
            end else begin
              idx <= idx + AW'(1);
            end
          end else if (tmr_zero) begin
            err_count <= err_inc;
            if (first) begin
              fail_code <= FC_TIMEOUT;
              fail_idx  <= idx;
            end
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        HALTCHK: begin
          if (step) begin
            err_count <= err_inc;
            if (first) begin
              fail_code <= FC_EXTRA;
              fail_idx  <= last_idx;
            end
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
          end else if (tmr_zero) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0);
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Bench for cpu_trace_checker: a CONT=0 and a CONT=1 instance share one CPU
// model; expected verdicts are queued per run and popped when done rises.
module tb_cpu_trace_checker;
  localparam int PC_W = 9, DATA_W = 16, DEPTH = 16, TIMEOUT = 64;
  localparam int RW = 3, AW = 4;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, exp_we = 1'b0, exp_ren = 1'b0, wb_en = 1'b0;
  logic [AW:0]       n_entries = '0;
  logic [AW-1:0]     exp_addr = '0;
  logic [PC_W-1:0]   exp_pc = '0, pc = '0;
  logic [RW-1:0]     exp_reg = '0, wb_reg = '0;
  logic [DATA_W-1:0] exp_data = '0, wb_data = '0;
  logic busy0, done0, pass0, busy1, done1, pass1;
  logic [2:0]    fc0, fc1;
  logic [AW-1:0] fi0, fi1;
  logic [AW:0]   ec0, ec1;

  cpu_trace_checker #(.CONT(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .n_entries(n_entries),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_pc(exp_pc), .exp_ren(exp_ren),
    .exp_reg(exp_reg), .exp_data(exp_data), .pc(pc), .wb_en(wb_en),
    .wb_reg(wb_reg), .wb_data(wb_data), .busy(busy0), .done(done0),
    .pass(pass0), .fail_code(fc0), .fail_idx(fi0), .err_count(ec0));

  cpu_trace_checker #(.CONT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .n_entries(n_entries),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_pc(exp_pc), .exp_ren(exp_ren),
    .exp_reg(exp_reg), .exp_data(exp_data), .pc(pc), .wb_en(wb_en),
    .wb_reg(wb_reg), .wb_data(wb_data), .busy(busy1), .done(done1),
    .pass(pass1), .fail_code(fc1), .fail_idx(fi1), .err_count(ec1));

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int code, idx, err, pass;
  } exp_t;

  typedef struct {
    string name;
    int kind, n;
    int c0, i0, e0, p0;
    int c1, i1, e1, p1;
    int ref_step, lat;
  } vec_t;

  exp_t q0[$], q1[$];
  vec_t vecs[10];
  int n_checks = 0, n_fail = 0, cyc = 0, t_done0 = 0;
  bit prev0 = 0, prev1 = 0, seen0 = 0, seen1 = 0;
  int pcs[16];
  int t_step[16];

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic pop_check(input int which);
    exp_t e;
    if (which == 0) begin
      if (q0.size() == 0) begin check("dut0 unexpected done", 1, 0); return; end
      e = q0.pop_front();
      check({e.name, " dut0 fail_code"}, int'(fc0), e.code);
      check({e.name, " dut0 fail_idx"},  int'(fi0), e.idx);
      check({e.name, " dut0 err_count"}, int'(ec0), e.err);
      check({e.name, " dut0 pass"},      int'(pass0), e.pass);
      check({e.name, " dut0 busy"},      int'(busy0), 0);
    end else begin
      if (q1.size() == 0) begin check("dut1 unexpected done", 1, 0); return; end
      e = q1.pop_front();
      check({e.name, " dut1 fail_code"}, int'(fc1), e.code);
      check({e.name, " dut1 fail_idx"},  int'(fi1), e.idx);
      check({e.name, " dut1 err_count"}, int'(ec1), e.err);
      check({e.name, " dut1 pass"},      int'(pass1), e.pass);
    end
  endtask

  // Every cycle passes through here: sample at negedge, pop on done rising.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (done0 && !prev0) begin pop_check(0); seen0 = 1; t_done0 = cyc; end
    if (done1 && !prev1) begin pop_check(1); seen1 = 1; end
    prev0 = done0;
    prev1 = done1;
  endtask

  task automatic start_run(input int n);
    seen0 = 0;
    seen1 = 0;
    tick();
    start = 1'b1;
    n_entries = n[AW:0];
    tick();
    start = 1'b0;
    check("start busy0", int'(busy0), 1);
    check("start done1", int'(done1), 0);
  endtask

  task automatic drive_step(input int s, input int pcv, input bit bad_r2);
    pc = pcv[PC_W-1:0];
    t_step[s] = cyc;
    wb_en = (s >= 1 && s <= 3);
    wb_reg = (s >= 1) ? RW'(s - 1) : '0;
    wb_data = (s == 1) ? DATA_W'(7) : (s == 2) ? DATA_W'(2) : (bad_r2 ? DATA_W'(17) : DATA_W'(16));
    tick();
    wb_en = 1'b0;
  endtask

  task automatic wait_verdicts(input string name);
    for (int k = 0; k < 300 && !(seen0 && seen1); k++) tick();
    if (!seen0) begin
      check({name, " dut0 verdict timeout"}, 0, 1);
      if (q0.size() > 0) void'(q0.pop_front());
    end
    if (!seen1) begin
      check({name, " dut1 verdict timeout"}, 0, 1);
      if (q1.size() > 0) void'(q1.pop_front());
    end
  endtask

  task automatic run_vec(input vec_t v);
    int nsteps;
    nsteps = (v.kind == 3) ? 4 : (v.kind == 4) ? 9 : (v.kind == 5) ? 1 : (v.kind == 6) ? 16 : 8;
    for (int s = 0; s < 16; s++) pcs[s] = s + 1;
    if (v.kind == 1 || v.kind == 7) pcs[2] = 5;
    if (v.kind == 7) pcs[7] = 9;
    if (v.kind == 8) pcs[3] = 6;
    q0.push_back('{v.name, v.c0, v.i0, v.e0, v.p0});
    q1.push_back('{v.name, v.c1, v.i1, v.e1, v.p1});
    start_run(v.n);
    for (int s = 0; s < nsteps; s++) begin
      repeat ((v.kind == 4 && s == 8) ? 10 : 2) tick();
      if (v.kind == 9 && s == 2) begin
        start = 1'b1; exp_we = 1'b1; exp_addr = AW'(5); exp_pc = PC_W'(99);
        tick();
        start = 1'b0; exp_we = 1'b0;
      end
      drive_step(s, pcs[s], (v.kind == 2 || v.kind == 8));
    end
    wait_verdicts(v.name);
    if (seen0) check({v.name, " dut0 done latency"}, t_done0 - t_step[v.ref_step - 1], v.lat);
    pc = '0;
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //        name            kind n   c0 i0 e0 p0  c1 i1 e1 p1  ref lat
    vecs[0] = '{"normal",       0, 8,  0, 0, 0, 1,  0, 0, 0, 1,  8, TIMEOUT+1};
    vecs[1] = '{"pc_mismatch",  1, 8,  1, 2, 1, 0,  1, 2, 1, 0,  3, 1};
    vecs[2] = '{"data_mismatch",2, 8,  2, 3, 1, 0,  2, 3, 1, 0,  4, 1};
    vecs[3] = '{"timeout",      3, 8,  3, 4, 1, 0,  3, 4, 1, 0,  4, TIMEOUT+1};
    vecs[4] = '{"extra_pc",     4, 8,  4, 7, 1, 0,  4, 7, 1, 0,  9, 1};
    vecs[5] = '{"n_zero",       5, 0,  0, 0, 0, 1,  0, 0, 0, 1,  1, TIMEOUT+1};
    vecs[6] = '{"n_over",       6, 20, 0, 0, 0, 1,  0, 0, 0, 1, 16, TIMEOUT+1};
    vecs[7] = '{"two_errors",   7, 8,  1, 2, 1, 0,  1, 2, 2, 0,  3, 1};
    vecs[8] = '{"both_bad",     8, 8,  1, 3, 1, 0,  1, 3, 1, 0,  4, 1};
    vecs[9] = '{"ignore_busy",  9, 8,  0, 0, 0, 1,  0, 0, 0, 1,  8, TIMEOUT+1};

    repeat (3) tick();
    check("reset busy0", int'(busy0), 0);
    check("reset done0", int'(done0), 0);
    check("reset pass0", int'(pass0), 0);
    check("reset fail_code0", int'(fc0), 0);
    check("reset fail_idx0", int'(fi0), 0);
    check("reset err_count0", int'(ec0), 0);
    check("reset busy1", int'(busy1), 0);
    check("reset done1", int'(done1), 0);
    check("reset pass1", int'(pass1), 0);
    check("reset fail_code1", int'(fc1), 0);
    check("reset fail_idx1", int'(fi1), 0);
    check("reset err_count1", int'(ec1), 0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      exp_we = 1'b1;
      exp_addr = AW'(i);
      exp_pc = PC_W'(i + 1);
      exp_ren = (i >= 1 && i <= 3);
      exp_reg = (i >= 1) ? RW'(i - 1) : '0;
      exp_data = (i == 1) ? DATA_W'(7) : (i == 2) ? DATA_W'(2) : (i == 3) ? DATA_W'(16) : '0;
      tick();
    end
    exp_we = 1'b0;
    exp_ren = 1'b0;

    for (int v = 0; v < 10; v++) run_vec(vecs[v]);

    // Reset in the middle of a run, then a fresh run on the retained table.
    start_run(8);
    for (int s = 0; s < 3; s++) begin
      repeat (2) tick();
      drive_step(s, s + 1, 1'b0);
    end
    reset = 1'b1;
    #1;
    check("midreset busy0", int'(busy0), 0);
    check("midreset busy1", int'(busy1), 0);
    check("midreset done0", int'(done0), 0);
    check("midreset err_count1", int'(ec1), 0);
    tick();
    reset = 1'b0;
    pc = '0;
    tick();
    vecs[0].name = "after_reset";
    run_vec(vecs[0]);

    // PC wrap from all-ones to zero is an ordinary step.
    exp_we = 1'b1; exp_addr = '0; exp_pc = '0; exp_ren = 1'b0;
    tick();
    exp_we = 1'b0;
    pc = '1;
    tick();
    q0.push_back('{"pc_wrap", 0, 0, 0, 1});
    q1.push_back('{"pc_wrap", 0, 0, 0, 1});
    start_run(1);
    repeat (2) tick();
    drive_step(0, 0, 1'b0);
    wait_verdicts("pc_wrap");
    if (seen0) check("pc_wrap dut0 done latency", t_done0 - t_step[0], TIMEOUT + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
